iob_iobuf_sw_xcvr: RTL and testbench

- Half-duplex, single-wire, open-drain serial transceiver.
- Drives one bidirectional pad through the tri-state IO buffer's I/T/O pins and frames DATA_W-bit words: start, data LSB-first, stop.
- Sits between core-side valid/ready logic and the pad buffer; both ends of a link use the same block.

---
 rtl/iob_iobuf_sw_xcvr.sv | 189 ++++++++++++++++++
 tb/tb_iob_iobuf_sw_xcvr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_iobuf_sw_xcvr.sv
// rtl/iob_iobuf_sw_xcvr.sv - half-duplex single-wire open-drain transceiver (start, LSB-first data, stop)
// Optional transmit readback abort: IOB_IOBUF_SW_XCVR_COLLISION_EN
module iob_iobuf_sw_xcvr #(
  parameter int DATA_W      = 8,
  parameter int BIT_CYCLES  = 16,
  parameter int TURN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err,
  output logic              busy,
  output logic              pad_i,
  output logic              pad_t,
  input  logic              pad_o
);

  localparam int CNT_W = $clog2(BIT_CYCLES > TURN_CYCLES ? BIT_CYCLES : TURN_CYCLES);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, RX_START, RX_DATA, RX_STOP, TURN
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIT_W-1:0]   bit_q;
  logic [DATA_W-1:0]  sh_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic               rx_valid_q;
  logic               rx_err_q;
  logic               pad_t_q;
  logic               sync1_q;
  logic               s_q;
  logic               s_prev_q;

  logic               fall;
  logic               accept;
  logic               bit_end;
  logic               collide;
  logic [CNT_W-1:0]   cnt_d;
  logic [DATA_W-1:0]  tx_next;
  logic [DATA_W-1:0]  rx_next;

  assign fall     = s_prev_q & ~s_q & (state_q == IDLE);
  assign tx_ready = (state_q == IDLE) & ~fall;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (cnt_q == BIT_LAST);
  assign cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
  assign tx_next  = DATA_W'({1'b1, sh_q} >> 1);
  assign rx_next  = DATA_W'({s_q, sh_q} >> 1);

`ifdef IOB_IOBUF_SW_XCVR_COLLISION_EN
  // Sampled one cycle past mid-bit so the 2-flop sync has caught up with our own release.
  localparam logic [CNT_W-1:0] MID = CNT_W'(BIT_CYCLES / 2);
  assign collide = pad_t_q & (cnt_q == MID) & ~s_q;
`else
  assign collide = 1'b0;
`endif

  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign rx_data  = rx_data_q;
  assign pad_t    = pad_t_q;
  assign pad_i    = 1'b0;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      pad_t_q    <= 1'b1;
      sync1_q    <= 1'b1;
      s_q        <= 1'b1;
      s_prev_q   <= 1'b1;
    end else begin
      sync1_q    <= pad_o;
      s_q        <= sync1_q;
      s_prev_q   <= s_q;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          bit_q   <= '0;
          pad_t_q <= 1'b1;
          if (fall) begin
            state_q <= RX_START;
          end else if (accept) begin
            state_q <= TX_START;
            sh_q    <= tx_data;
            pad_t_q <= 1'b0;
          end
        end
        TX_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= TX_DATA;
            pad_t_q <= sh_q[0];
          end
        end
        TX_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            sh_q <= tx_next;
            if (bit_q == DATA_LAST) begin
              state_q <= TX_STOP;
              bit_q   <= '0;
              pad_t_q <= 1'b1;
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              pad_t_q <= tx_next[0];
            end
          end
          if (collide) begin
            state_q  <= TURN;
            cnt_q    <= '0;
            pad_t_q  <= 1'b1;
            rx_err_q <= 1'b1;
          end
        end
        TX_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) state_q <= TURN;
          if (collide) begin
            state_q  <= TURN;
            cnt_q    <= '0;
            rx_err_q <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= s_q ? TURN : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            sh_q  <= rx_next;
            bit_q <= bit_q + BIT_W'(1);
            if (bit_q == DATA_LAST) begin
              state_q <= RX_STOP;
              bit_q   <= '0;
            end
          end
        end
        RX_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= TURN;
            if (s_q) begin
              rx_data_q  <= sh_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
          end
        end
        TURN: begin
          pad_t_q <= 1'b1;
          if (cnt_q == TURN_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_iobuf_sw_xcvr.sv
// tb/tb_iob_iobuf_sw_xcvr.sv - two transceivers on a wired-AND bus plus an external open-drain driver
module tb_iob_iobuf_sw_xcvr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ext_n = 1'b1;
  logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic [7:0] tx_data_a = '0, tx_data_b = '0;
  logic       tx_ready_a, tx_ready_b, rx_valid_a, rx_valid_b, rx_err_a, rx_err_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       busy_a, busy_b, pad_i_a, pad_i_b, pad_t_a, pad_t_b;
  logic       bus;

  int n_assert = 0;
  int n_fail   = 0;
  int nv_a = 0, nv_b = 0, ne_a = 0, ne_b = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  assign bus = (pad_t_a ? 1'b1 : pad_i_a) & (pad_t_b ? 1'b1 : pad_i_b) & ext_n;

  iob_iobuf_sw_xcvr #(.DATA_W(8), .BIT_CYCLES(8), .TURN_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_err(rx_err_a), .busy(busy_a),
    .pad_i(pad_i_a), .pad_t(pad_t_a), .pad_o(bus));

  iob_iobuf_sw_xcvr #(.DATA_W(8), .BIT_CYCLES(8), .TURN_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_err(rx_err_b), .busy(busy_b),
    .pad_i(pad_i_b), .pad_t(pad_t_b), .pad_o(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive_level(input logic v, input int n);
    ext_n = v;
    tick(n);
  endtask

  task automatic send_ext(input logic [7:0] d, input logic stop);
    drive_level(1'b0, 8);
    for (int i = 0; i < 8; i++) drive_level(d[i], 8);
    drive_level(stop, 8);
    ext_n = 1'b1;
  endtask

  // A transmits d; checks the pad waveform cycle by cycle and the tx_ready return.
  task automatic tx_a_checked(input logic [7:0] d);
    logic exp_t;
    check("a_ready_pre", tx_ready_a, 1);
    tx_valid_a = 1'b1;
    tx_data_a  = d;
    qb.push_back(d);
    tick(1);
    tx_valid_a = 1'b0;
    for (int c = 1; c <= 85; c++) begin
      if (c <= 8) exp_t = 1'b0;
      else if (c <= 72) exp_t = d[(c - 9) / 8];
      else exp_t = 1'b1;
      check("a_pad_t", pad_t_a, exp_t);
      check("a_tx_ready", tx_ready_a, (c == 85));
      tick(1);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (rx_valid_a || rx_err_a) check("a_valid_err_excl", rx_valid_a & rx_err_a, 0);
      if (rx_valid_b || rx_err_b) check("b_valid_err_excl", rx_valid_b & rx_err_b, 0);
      if (rx_err_a) ne_a++;
      if (rx_err_b) ne_b++;
      if (rx_valid_a) begin
        nv_a++;
        if (qa.size() == 0) check("a_rx_unexpected", rx_valid_a, 0);
        else begin
          e = qa.pop_front();
          check("a_rx_data", rx_data_a, e);
        end
      end
      if (rx_valid_b) begin
        nv_b++;
        if (qb.size() == 0) check("b_rx_unexpected", rx_valid_b, 0);
        else begin
          e = qb.pop_front();
          check("b_rx_data", rx_data_b, e);
        end
      end
    end
  end

  initial begin
    int sv_a, sv_b, se_a, se_b;
    int ready_c;

    // reset and idle
    tick(3);
    check("rst_pad_t", pad_t_a, 1);
    check("rst_pad_i", pad_i_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_rx_err", rx_err_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    rst_n = 1'b1;
    tick(2);
    check("idle_tx_ready", tx_ready_a, 1);
    check("idle_pad_t_b", pad_t_b, 1);

    // A -> B frames, A ignores its own frame
    tx_a_checked(8'hA5);
    tick(10);
    tx_a_checked(8'h3C);
    tick(10);
    check("a_no_self_rx", nv_a, 0);
    check("b_rx_count", nv_b, 2);
    check("b_rx_last", rx_data_b, 8'h3C);

    // bad stop bit, then good frame
    se_a = ne_a; se_b = ne_b; sv_a = nv_a; sv_b = nv_b;
    send_ext(8'h5A, 1'b0);
    tick(10);
    check("bad_stop_err_a", ne_a - se_a, 1);
    check("bad_stop_err_b", ne_b - se_b, 1);
    check("bad_stop_nv_b", nv_b - sv_b, 0);
    check("bad_stop_keep_a", rx_data_a, 8'h00);
    check("bad_stop_keep_b", rx_data_b, 8'h3C);
    qa.push_back(8'h81);
    qb.push_back(8'h81);
    send_ext(8'h81, 1'b1);
    tick(10);
    check("good_rx_a", rx_data_a, 8'h81);
    check("good_rx_b", rx_data_b, 8'h81);
    check("good_nv_a", nv_a - sv_a, 1);

    // tx_valid on the fall cycle: receive wins, word goes out after rx + turn
    qa.push_back(8'h4B);
    qb.push_back(8'h4B);
    qb.push_back(8'h77);
    drive_level(1'b0, 2);
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h77;
    check("fall_blocks_ready", tx_ready_a, 0);
    drive_level(1'b0, 6);
    for (int i = 0; i < 8; i++) drive_level(sv_a[0] | 1'b1 ? 1'(8'h4B >> i) : 1'b0, 8);
    drive_level(1'b1, 8);
    tick(2);
    check("rx_turn_ready_low", tx_ready_a, 0);
    tick(1);
    check("rx_turn_ready_high", tx_ready_a, 1);
    tick(1);
    tx_valid_a = 1'b0;
    check("deferred_tx_started", pad_t_a, 0);
    tick(95);
    check("deferred_b_rx", rx_data_b, 8'h77);

    // short glitch
    se_a = ne_a; se_b = ne_b; sv_a = nv_a; sv_b = nv_b;
    drive_level(1'b0, 2);
    ext_n = 1'b1;
    tick(30);
    check("glitch_nv", (nv_a - sv_a) + (nv_b - sv_b), 0);
    check("glitch_ne", (ne_a - se_a) + (ne_b - se_b), 0);
    check("glitch_idle", busy_a | busy_b, 0);

    // foreign driver pulls the line low across bits 3-4 of an 0xFF frame
    se_a = ne_a;
`ifdef IOB_IOBUF_SW_XCVR_COLLISION_EN
    ready_c = 50;
`else
    ready_c = 85;
`endif
    qb.push_back(8'hE7);
    check("coll_ready_pre", tx_ready_a, 1);
    tx_valid_a = 1'b1;
    tx_data_a  = 8'hFF;
    tick(1);
    tx_valid_a = 1'b0;
    for (int c = 1; c <= 85; c++) begin
      if (c == 37) ext_n = 1'b0;
      if (c == 49) ext_n = 1'b1;
      if (c == ready_c - 1) check("coll_ready_low", tx_ready_a, 0);
      if (c == ready_c) check("coll_ready_high", tx_ready_a, 1);
      if (c > 8 && c <= ready_c) check("coll_pad_t", pad_t_a, 1);
      tick(1);
    end
    tick(10);
`ifdef IOB_IOBUF_SW_XCVR_COLLISION_EN
    check("coll_err_a", ne_a - se_a, 1);
`else
    check("coll_err_a", ne_a - se_a, 0);
`endif
    check("coll_b_rx", rx_data_b, 8'hE7);

    // reset mid-frame releases the pad at once and drops the word
    sv_b = nv_b; se_b = ne_b;
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h00;
    tick(1);
    tx_valid_a = 1'b0;
    tick(20);
    check("midframe_pad_low", pad_t_a, 0);
    rst_n = 1'b0;
    #1;
    check("rst_async_pad_t", pad_t_a, 1);
    check("rst_async_busy_b", busy_b, 0);
    tick(1);
    rst_n = 1'b1;
    tick(100);
    check("rst_drop_nv_b", nv_b - sv_b, 0);
    check("rst_drop_ne_b", ne_b - se_b, 0);
    check("rst_rx_data_b", rx_data_b, 0);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
